// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default line parameters
// used by both the receive and transmit paths.
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // 100 MHz system clock at 9600 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 10416;
    // Payload bits per frame (8N1).
    localparam int DEFAULT_DATA_BITS    = 8;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is held in a
// register so the read side only changes on a clock edge and reads 0 after reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);

    // Next pointers and next head; a byte written this cycle that becomes the head is forwarded.
    always_comb begin
        wr_ptr_next = wr_ptr_reg + PW'(push_ok);
        rd_ptr_next = rd_ptr_reg + PW'(pop_ok);
        head_next   = mem[rd_ptr_next[AW-1:0]];
        if (push_ok && (rd_ptr_next[AW-1:0] == wr_ptr_reg[AW-1:0])) begin
            head_next = push_data;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Pointer and head register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            head_reg   <= head_next;
        end
    end

    assign head_data = head_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// Buffered 8N1 UART receiver: synchronizes the raw line, recovers frames
// with a mid-bit sampling FSM and queues bytes in a FWFT FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                 clk,
    input  logic                 i_reset_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic [1:0]           sync_reg;
    logic                 rx_s;
    rx_state_t            state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 push_reg, push_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 overrun_reg;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    // Two-flop synchronizer on the asynchronous line; resets to the idle level.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], i_rx};
        end
    end

    assign rx_s = sync_reg[1];

    // Receiver state, counters and registered pulses.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            push_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            push_reg      <= push_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Frame recovery: half a bit to the start-bit centre, then one bit period per sample.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        push_next      = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    // A start bit that is gone by its centre was a glitch.
                    state_next   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
                    bit_idx_next = bit_idx_reg + IDX_W'(1);
                    if (bit_idx_reg == IDX_LAST) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        push_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = BREAK;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a held-low line is not seen as a new start.
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pop = o_valid && i_ready;

    // Overrun pulse: a completed byte arrives while full and nothing leaves this cycle.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= push_reg && fifo_full && !pop;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (i_reset_n),
        .push      (push_reg),
        .push_data (shift_reg),
        .pop       (pop),
        .head_data (o_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign o_valid     = !fifo_empty;
    assign o_frame_err = frame_err_reg;
    assign o_overrun   = overrun_reg;
    assign o_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random frames
// checked against a queue-based model of the byte stream.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_rx = 1'b1;
    logic          i_ready = 1'b0;
    logic [DB-1:0] o_data;
    logic          o_valid;
    logic          o_frame_err;
    logic          o_overrun;
    logic          o_busy;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_BITS    (DB),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .i_reset_n   (i_reset_n),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    int        n_assert = 0;
    int        n_fail   = 0;
    logic [7:0] got_q[$];
    int        ferr_seen    = 0;
    int        ovr_seen     = 0;
    int        valid_cycles = 0;

    // Observe the consumer port away from the active edge.
    always @(negedge clk) begin
        if (i_reset_n) begin
            if (o_valid) valid_cycles++;
            if (o_valid && i_ready) begin
                got_q.push_back(o_data);
                $display("[%0t] byte accepted 0x%02h", $time, o_data);
            end
            if (o_frame_err) ferr_seen++;
            if (o_overrun)   ovr_seen++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] got_at(input int i);
        logic [7:0] v;
        v = 8'hxx;
        if (i < got_q.size()) v = got_q[i];
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one 8N1 frame; ready_at >= 0 raises i_ready for exactly that cycle of the frame.
    task automatic send(input logic [7:0] b, input logic stop, input int ready_at);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            @(posedge clk);
            #1;
            i_rx = f[c / CPB];
            if (c == ready_at) i_ready = 1'b1;
            else if (ready_at >= 0 && c == ready_at + 1) i_ready = 1'b0;
        end
        $display("[%0t] frame sent data=0x%02h stop=%0b", $time, b, stop);
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int budget;
        budget = 40 * CPB;
        while (got_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        tick(1);
        check(got_q.size(), n, tag);
    endtask

    initial begin
        int base, f0, o0, v0, fe_exp;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic st;

        // Reset values.
        i_reset_n = 1'b0;
        tick(3);
        check(o_valid, 0, "rst_valid");
        check(o_data, 0, "rst_data");
        check(o_frame_err, 0, "rst_frame_err");
        check(o_overrun, 0, "rst_overrun");
        check(o_busy, 0, "rst_busy");
        i_reset_n = 1'b1;
        tick(4);

        // Reset in the middle of a frame, then a clean frame.
        i_rx = 1'b0;
        tick(3 * CPB);
        check(o_busy, 1, "midframe_busy");
        i_reset_n = 1'b0;
        #1;
        check(o_busy, 0, "async_rst_busy");
        check(o_valid, 0, "async_rst_valid");
        i_rx = 1'b1;
        tick(4);
        i_reset_n = 1'b1;
        tick(4);
        check(o_busy, 0, "post_rst_busy");
        i_ready = 1'b1;
        send(8'hA5, 1'b1, -1);
        wait_bytes(1, "a5_count");
        check(got_at(0), 8'hA5, "a5_data");

        // Single frame.
        tick(4);
        base = got_q.size(); f0 = ferr_seen; o0 = ovr_seen; v0 = valid_cycles;
        send(8'h3C, 1'b1, -1);
        wait_bytes(base + 1, "3c_count");
        tick(4);
        check(got_at(base), 8'h3C, "3c_data");
        check(valid_cycles - v0, 1, "3c_valid_width");
        check(ferr_seen - f0, 0, "3c_no_ferr");
        check(ovr_seen - o0, 0, "3c_no_ovr");

        // Glitch on the line.
        base = got_q.size(); f0 = ferr_seen;
        i_rx = 1'b0;
        tick(5);
        i_rx = 1'b1;
        tick(8);
        check(o_busy, 0, "glitch_busy");
        tick(CPB * 12);
        check(got_q.size(), base, "glitch_no_byte");
        check(ferr_seen - f0, 0, "glitch_no_ferr");

        // Framing error followed by a held-low line.
        base = got_q.size(); f0 = ferr_seen;
        send(8'h55, 1'b0, -1);
        tick(3 * CPB);
        check(o_busy, 1, "break_busy");
        check(ferr_seen - f0, 1, "ferr_pulse");
        check(got_q.size(), base, "ferr_no_byte");
        i_rx = 1'b1;
        tick(6);
        check(o_busy, 0, "break_exit");
        send(8'h81, 1'b1, -1);
        wait_bytes(base + 1, "81_count");
        check(got_at(base), 8'h81, "81_data");
        check(ferr_seen - f0, 1, "81_no_extra_ferr");

        // Overrun with backpressure, then drain.
        i_ready = 1'b0;
        tick(4);
        base = got_q.size(); o0 = ovr_seen;
        for (int k = 1; k <= 5; k++) send(8'(k), 1'b1, -1);
        tick(4);
        check(ovr_seen - o0, 1, "ovr_pulse");
        check(o_valid, 1, "ovr_valid");
        check(o_data, 8'h01, "ovr_head");
        check(got_q.size(), base, "ovr_held");
        i_ready = 1'b1;
        tick(DEPTH);
        check(o_valid, 0, "drain_empty");
        check(got_q.size(), base + DEPTH, "drain_count");
        for (int k = 0; k < DEPTH; k++) check(got_at(base + k), k + 1, "drain_data");

        // Push and pop in the same cycle while full.
        i_ready = 1'b0;
        tick(4);
        for (int k = 0; k < DEPTH; k++) send(8'h10 + 8'(k), 1'b1, -1);
        tick(4);
        base = got_q.size(); o0 = ovr_seen;
        // The push lands 3 + CPB/2 + 9*CPB cycles after the start bit is driven.
        send(8'h77, 1'b1, 3 + CPB / 2 + 9 * CPB);
        tick(4);
        check(ovr_seen - o0, 0, "simul_no_ovr");
        check(got_at(base), 8'h10, "simul_popped");
        i_ready = 1'b1;
        wait_bytes(base + DEPTH + 1, "simul_count");
        for (int k = 1; k < DEPTH; k++) check(got_at(base + k), 8'h10 + 8'(k), "simul_data");
        check(got_at(base + DEPTH), 8'h77, "simul_last");

        // Random frames with occasional bad stop bits against a queue model.
        tick(4);
        base = got_q.size(); f0 = ferr_seen; fe_exp = 0;
        for (int n = 0; n < 10; n++) begin
            b  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 4) != 0);
            send(b, st, -1);
            i_rx = 1'b1;
            if (st) exp_q.push_back(b);
            else fe_exp++;
            tick($urandom_range(4, 20));
        end
        tick(2 * CPB);
        check(got_q.size(), base + exp_q.size(), "rand_count");
        check(ferr_seen - f0, fe_exp, "rand_ferr");
        for (int k = 0; k < exp_q.size(); k++) check(got_at(base + k), exp_q[k], "rand_data");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
